// File: rtl/md_lut_pkg.sv
`default_nettype none
// ============================================================================
// md_lut_pkg : coefficient LUT geometry, arbiter FSM states and read tag type
// Revision   : 1.0
// ============================================================================
package md_lut_pkg;

    localparam int COEFF_BINS     = 256;
    localparam int COEFF_SEGMENTS = 14;
    localparam int COEFF_DEPTH    = COEFF_BINS * COEFF_SEGMENTS;

    // Upper bound on requesters; the tag id field is sized to this.
    localparam int MAX_REQ        = 16;

    typedef enum logic [1:0] {
        SERVE  = 2'd0,
        DRAIN  = 2'd1,
        CONFIG = 2'd2
    } lut_state_t;

    typedef struct packed {
        logic               valid;
        logic [MAX_REQ-1:0] id;
        logic               err;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, priority starts after `last`
// Revision   : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/coeff_lut_arbiter.sv
`default_nettype none
// ============================================================================
// coeff_lut_arbiter : round-robin sharing of one coefficient RAM between
//                     read pipelines, with drain-then-write host reload mode
// Revision          : 1.0
// ============================================================================
module coeff_lut_arbiter
    import md_lut_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = COEFF_DEPTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    input  logic                          cfg_mode,
    output logic                          cfg_active,
    input  logic                          cfg_wr_valid,
    input  logic [ADDR_WIDTH-1:0]         cfg_wr_addr,
    input  logic [DATA_WIDTH-1:0]         cfg_wr_data,
    output logic                          cfg_wr_ready,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic [DATA_WIDTH-1:0]         mem_data,
    output logic                          mem_rden,
    output logic                          mem_wren,
    input  logic [DATA_WIDTH-1:0]         mem_q
);

    localparam int                    c_idx_w     = $clog2(NUM_REQ);
    localparam int                    c_cnt_w     = $clog2(RD_LATENCY + 2);
    localparam logic [c_cnt_w-1:0]    c_cnt_one   = 1;
    localparam logic [ADDR_WIDTH:0]   c_depth_ext = DEPTH[ADDR_WIDTH:0];
    localparam logic [c_idx_w-1:0]    c_last_rst  = c_idx_w'(NUM_REQ - 1);

    lut_state_t              r_state;
    logic [c_idx_w-1:0]      r_last;
    logic                    r_cfg_active;
    logic [c_cnt_w-1:0]      r_inflight;
    tag_t                    r_tag [RD_LATENCY+1];
    logic                    r_mem_rden;
    logic                    r_mem_wren;
    logic [ADDR_WIDTH-1:0]   r_mem_address;
    logic [DATA_WIDTH-1:0]   r_mem_data;

    logic [NUM_REQ-1:0]      w_grant;
    logic [NUM_REQ-1:0]      w_ready;
    logic                    w_serve;
    logic                    w_accept;
    logic [c_idx_w-1:0]      w_grant_idx;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic                    w_sel_ok;
    logic                    w_wr_ok;
    logic                    w_rsp_now;
    tag_t                    w_new_tag;
    logic                    w_unused_tag_id;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_arbiter (
        .req   (req_valid),
        .last  (r_last),
        .grant (w_grant)
    );

    // Grants stop in the very cycle the host raises cfg_mode.
    assign w_serve  = (r_state == SERVE) && !cfg_mode && !rst;
    assign w_ready  = w_serve ? w_grant : '0;
    assign w_accept = |w_ready;

    always_comb begin
        w_grant_idx = '0;
        w_sel_addr  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = c_idx_w'(i);
                w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign w_sel_ok  = {1'b0, w_sel_addr} < c_depth_ext;
    assign w_wr_ok   = r_cfg_active && cfg_wr_valid && ({1'b0, cfg_wr_addr} < c_depth_ext);
    assign w_rsp_now = r_tag[RD_LATENCY].valid;

    always_comb begin
        w_new_tag                 = '0;
        w_new_tag.valid           = w_accept;
        w_new_tag.id[NUM_REQ-1:0] = w_ready;
        w_new_tag.err             = w_accept && !w_sel_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SERVE;
            r_cfg_active <= 1'b0;
            r_last       <= c_last_rst;
        end else begin
            if (w_accept) begin
                r_last <= w_grant_idx;
            end
            case (r_state)
                SERVE: begin
                    if (cfg_mode) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!cfg_mode) begin
                        r_state <= SERVE;
                    end else if (r_inflight == '0) begin
                        r_state      <= CONFIG;
                        r_cfg_active <= 1'b1;
                    end
                end
                CONFIG: begin
                    if (!cfg_mode) begin
                        r_state      <= SERVE;
                        r_cfg_active <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= SERVE;
                    r_cfg_active <= 1'b0;
                end
            endcase
        end
    end

    // Tag pipeline: a tag loaded on accept reaches the last stage as mem_q lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= RD_LATENCY; k++) begin
                r_tag[k] <= '0;
            end
            r_inflight <= '0;
        end else begin
            r_tag[0] <= w_new_tag;
            for (int k = 1; k <= RD_LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
            if (w_accept && !w_rsp_now) begin
                r_inflight <= r_inflight + c_cnt_one;
            end else if (!w_accept && w_rsp_now) begin
                r_inflight <= r_inflight - c_cnt_one;
            end
        end
    end

    // Reads and writes are mutually exclusive by state, so one address register serves both.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_rden    <= 1'b0;
            r_mem_wren    <= 1'b0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
        end else begin
            r_mem_rden <= w_accept && w_sel_ok;
            r_mem_wren <= w_wr_ok;
            if (w_accept && w_sel_ok) begin
                r_mem_address <= w_sel_addr;
            end else if (w_wr_ok) begin
                r_mem_address <= cfg_wr_addr;
            end
            if (w_wr_ok) begin
                r_mem_data <= cfg_wr_data;
            end
        end
    end

    assign req_ready    = w_ready;
    assign cfg_active   = r_cfg_active;
    assign cfg_wr_ready = r_cfg_active;
    assign mem_rden     = r_mem_rden;
    assign mem_wren     = r_mem_wren;
    assign mem_address  = r_mem_address;
    assign mem_data     = r_mem_data;

    assign rsp_valid = w_rsp_now ? r_tag[RD_LATENCY].id[NUM_REQ-1:0] : '0;
    assign rsp_err   = w_rsp_now && r_tag[RD_LATENCY].err;
    assign rsp_data  = (w_rsp_now && !r_tag[RD_LATENCY].err) ? mem_q : '0;

    assign w_unused_tag_id = |r_tag[RD_LATENCY].id;

endmodule
`default_nettype wire

// File: tb/tb_coeff_lut_arbiter.sv
`default_nettype none
// tb_coeff_lut_arbiter : randomized scoreboard bench with a RAM model and
//                        a round-robin reference for the coefficient arbiter
module tb_coeff_lut_arbiter;

    localparam int N     = 4;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 3584;
    localparam int LAT   = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            cfg_mode = 1'b0;
    logic            cfg_active;
    logic            cfg_wr_valid = 1'b0;
    logic [AW-1:0]   cfg_wr_addr = '0;
    logic [DW-1:0]   cfg_wr_data = '0;
    logic            cfg_wr_ready;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_data;
    logic            mem_rden;
    logic            mem_wren;
    logic [DW-1:0]   mem_q = '0;

    coeff_lut_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .RD_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .cfg_mode     (cfg_mode),
        .cfg_active   (cfg_active),
        .cfg_wr_valid (cfg_wr_valid),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_data  (cfg_wr_data),
        .cfg_wr_ready (cfg_wr_ready),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_rden     (mem_rden),
        .mem_wren     (mem_wren),
        .mem_q        (mem_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM behaves like the lutX_Y instance: registered q one cycle after rden.
    logic [DW-1:0] ram   [0:4095];
    logic [DW-1:0] model [0:4095];
    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        if (mem_rden) mem_q <= ram[mem_address];
    end

    typedef struct {
        int           due;
        logic [N-1:0] id;
        logic [DW-1:0] data;
        logic         err;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int rr_last  = N - 1;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_checks++;
        $display("FAIL %s: observed %0h (cycle %0d)", name, act, cyc);
    endtask

    // Response monitor: pops the scoreboard whenever a response strobe appears.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                fail_now("rsp_missing", 64'(sb[0].id));
                void'(sb.pop_front());
            end
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    fail_now("rsp_unexpected", 64'(rsp_valid));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_latency", 64'(cyc), 64'(e.due));
                    check("rsp_valid", 64'(rsp_valid), 64'(e.id));
                    check("rsp_data", 64'(rsp_data), 64'(e.data));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                end
            end else begin
                check("idle_rsp_data_err", {31'b0, rsp_err, rsp_data}, 64'd0);
            end
            if (mem_rden && mem_wren) fail_now("rden_wren_both", 64'd3);
        end
    end

    function automatic logic [N*AW-1:0] rand_addrs();
        logic [N*AW-1:0] a;
        for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'($urandom_range(0, 4095));
        return a;
    endfunction

    // One serving cycle: the reference picks the first valid requester after rr_last.
    task automatic issue(input logic [N-1:0] v, input logic [N*AW-1:0] addrs);
        logic [N-1:0] exp_g;
        int           w;
        int           a;
        exp_t         e;
        @(posedge clk); #1;
        req_valid    = v;
        req_addr     = addrs;
        cfg_wr_valid = 1'b0;
        @(negedge clk);
        exp_g = '0;
        w     = -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (rr_last + k) % N;
            if (w < 0 && v[i]) w = i;
        end
        if (w >= 0) exp_g[w] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_g));
        if (w >= 0) begin
            rr_last = w;
            a       = int'(addrs[w*AW +: AW]);
            e.due   = cyc + 1 + LAT;
            e.id    = exp_g;
            e.err   = (a >= DEPTH);
            e.data  = (a >= DEPTH) ? '0 : model[a];
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        req_valid    = '0;
        cfg_wr_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_data}, 64'd0);
        check({tag, "_mem_ctl"}, {62'd0, mem_rden, mem_wren}, 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_address), 64'd0);
        check({tag, "_mem_data"}, 64'(mem_data), 64'd0);
        check({tag, "_cfg"}, {62'd0, cfg_active, cfg_wr_ready}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int i = 0; i < 4096; i++) begin
            model[i] = $urandom();
            ram[i]   = model[i];
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        check("reset_ready", 64'(req_ready), 64'd0);
        mon_en = 1'b1;

        // Single read from requester 0
        issue(4'b0001, {12'h0, 12'h0, 12'h0, 12'h005});
        idle();
        check("rd_mem_rden", 64'(mem_rden), 64'd1);
        check("rd_mem_addr", 64'(mem_address), 64'h005);
        repeat (2) idle();

        // All four requesting back-to-back
        for (int c = 0; c < 8; c++) issue(4'b1111, {12'h013, 12'h012, 12'h011, 12'h010});
        repeat (3) idle();

        // Out-of-range read from requester 2
        issue(4'b0100, {12'h0, 12'hE00, 12'h0, 12'h0});
        idle();
        check("oor_mem_rden", 64'(mem_rden), 64'd0);
        repeat (2) idle();

        // Randomized traffic
        for (int c = 0; c < 150; c++) issue(4'($urandom_range(0, 15)), rand_addrs());
        repeat (3) idle();

        // Host write attempted while serving must not reach the RAM
        @(posedge clk); #1;
        cfg_wr_valid = 1'b1; cfg_wr_addr = 12'h00B; cfg_wr_data = 32'h1234_5678;
        @(negedge clk);
        idle();
        check("serve_wr_ignored", 64'(mem_wren), 64'd0);
        issue(4'b1000, {12'h00B, 12'h0, 12'h0, 12'h0});
        repeat (3) idle();

        // Reload: reads in flight, then cfg_mode
        issue(4'b1111, rand_addrs());
        issue(4'b1111, rand_addrs());
        @(posedge clk); #1;
        cfg_mode = 1'b1;
        @(negedge clk);
        check("drain_no_grant", 64'(req_ready), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("drain_no_grant", 64'(req_ready), 64'd0);
            if (cfg_active) begin
                seen = 1'b1;
                check("cfg_after_last_rsp", 64'(sb.size()), 64'd0);
                check("cfg_wr_ready", 64'(cfg_wr_ready), 64'd1);
            end
        end
        if (!seen) fail_now("cfg_active_timeout", 64'(cfg_active));
        req_valid = '0;

        @(posedge clk); #1;
        cfg_wr_valid = 1'b1; cfg_wr_addr = 12'h00A; cfg_wr_data = 32'hDEAD_BEEF;
        model[10] = 32'hDEAD_BEEF;
        @(negedge clk);
        @(posedge clk); #1;
        cfg_wr_addr = 12'hF00; cfg_wr_data = 32'hFFFF_FFFF;
        @(negedge clk);
        check("wr_mem_wren", 64'(mem_wren), 64'd1);
        check("wr_mem_addr", 64'(mem_address), 64'h00A);
        check("wr_mem_data", 64'(mem_data), 64'hDEAD_BEEF);
        @(posedge clk); #1;
        cfg_wr_valid = 1'b0;
        cfg_mode     = 1'b0;
        @(negedge clk);
        check("oor_wr_dropped", 64'(mem_wren), 64'd0);
        check("cfg_active_hold", 64'(cfg_active), 64'd1);
        issue(4'b0001, {12'h0, 12'h0, 12'h0, 12'h00A});
        check("cfg_active_fall", 64'(cfg_active), 64'd0);
        repeat (3) idle();

        // cfg_mode pulsed for one cycle while reads drain
        issue(4'b1111, rand_addrs());
        issue(4'b1111, rand_addrs());
        @(posedge clk); #1;
        cfg_mode = 1'b1;
        @(negedge clk);
        check("pulse_no_grant", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        cfg_mode  = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("pulse_drain_no_grant", 64'(req_ready), 64'd0);
        for (int c = 0; c < 5; c++) begin
            idle();
            check("pulse_cfg_inactive", 64'(cfg_active), 64'd0);
        end
        for (int c = 0; c < 10; c++) issue(4'($urandom_range(1, 15)), rand_addrs());
        repeat (3) idle();

        // Synchronous reset with reads in flight
        issue(4'b1111, rand_addrs());
        issue(4'b1111, rand_addrs());
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = '0;
        sb.delete();
        rr_last   = N - 1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        issue(4'b1111, {12'h003, 12'h002, 12'h001, 12'h000});
        repeat (4) idle();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
